// File: rtl/elastic_fifo_shift.sv
// rtl/elastic_fifo_shift.sv - elastic FIFO storing left-shifted words, ready driven only from registered state
module elastic_fifo_shift #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SHIFT  = 2,
    parameter int AFULL  = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] t0_data,
    input  logic              t0_valid,
    output logic              t0_ready,
    output logic [DATA_W-1:0] i0_data,
    output logic              i0_valid,
    input  logic              i0_ready,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              afull_q, afull_d;
    logic              push, pop;

    // Ready never looks at i0_ready: a pop while full frees the slot only next cycle.
    assign t0_ready    = !rst && (count_q != CNT_W'(DEPTH));
    assign i0_valid    = (count_q != '0);
    assign i0_data     = i0_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign almost_full = afull_q;

    assign push = t0_valid && t0_ready;
    assign pop  = i0_valid && i0_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        afull_d = (count_d >= CNT_W'(AFULL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is never cleared; push is already blocked during reset through t0_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= t0_data << SHIFT;
        end
    end
endmodule

// File: tb/tb_elastic_fifo_shift.sv
// tb/tb_elastic_fifo_shift.sv - self-checking bench for elastic_fifo_shift against a queue model
module tb_elastic_fifo_shift;
    logic        clk;
    logic        rst;
    logic [31:0] t0_data;
    logic        t0_valid;
    logic        t0_ready;
    logic [31:0] i0_data;
    logic        i0_valid;
    logic        i0_ready;
    logic [2:0]  count;
    logic        almost_full;

    int n_cmp;
    int n_fail;
    logic [31:0] mq[$];

    elastic_fifo_shift dut (
        .clk(clk), .rst(rst),
        .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .count(count), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and apply the same transfer rules to the queue model.
    task automatic tick();
        bit pu, po;
        logic [31:0] w;
        pu = !rst && t0_valid && (mq.size() < 4);
        po = !rst && i0_ready && (mq.size() > 0);
        w  = t0_data << 2;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
        end else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(w);
        end
    endtask

    function automatic logic [31:0] model_head();
        return (mq.size() > 0) ? mq[0] : 32'h0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; t0_valid = 1'b0; i0_ready = 1'b0; t0_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; t0_valid = 1'b1; t0_data = 32'h5; i0_ready = 1'b0;
        #1;
        n_cmp++; if (t0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_comb: got %b expected 0", t0_ready); end
        tick();
        n_cmp++; if (t0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", t0_ready); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (i0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", i0_valid); end
        n_cmp++; if (i0_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", i0_data); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b expected 0", almost_full); end
        tick();
        rst = 1'b0; t0_data = 32'h1;
        #1;
        n_cmp++; if (t0_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", t0_ready); end
        tick();
        t0_valid = 1'b0;
        n_cmp++; if (i0_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", i0_valid); end
        n_cmp++; if (i0_data !== 32'h4) begin n_fail++; $display("FAIL single_data: got %h expected 00000004", i0_data); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        i0_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            t0_valid = 1'b1; t0_data = 32'(k * 16);
            tick();
            n_cmp++; if (count !== 3'(k)) begin n_fail++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count, k); end
            n_cmp++; if (almost_full !== (k >= 3)) begin n_fail++; $display("FAIL fill_afull%0d: got %b expected %b", k, almost_full, k >= 3); end
            n_cmp++; if (t0_ready !== (k < 4)) begin n_fail++; $display("FAIL fill_ready%0d: got %b expected %b", k, t0_ready, k < 4); end
        end
        t0_data = 32'hDEAD;
        for (int s = 0; s < 10; s++) begin
            tick();
            n_cmp++; if (i0_data !== 32'h40) begin n_fail++; $display("FAIL stall_data%0d: got %h expected 00000040", s, i0_data); end
            n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL stall_count%0d: got %0d expected 4", s, count); end
        end
    endtask

    task automatic test_full_pop();
        t0_valid = 1'b1; t0_data = 32'h99; i0_ready = 1'b1;
        #1;
        n_cmp++; if (t0_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_before: got %b expected 0", t0_ready); end
        n_cmp++; if (i0_data !== 32'h40) begin n_fail++; $display("FAIL fullpop_head: got %h expected 00000040", i0_data); end
        tick();
        i0_ready = 1'b0; t0_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 3", count); end
        n_cmp++; if (t0_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready_after: got %b expected 1", t0_ready); end
        n_cmp++; if (i0_data !== 32'h80) begin n_fail++; $display("FAIL fullpop_next: got %h expected 00000080", i0_data); end
        n_cmp++; if (i0_data !== model_head()) begin n_fail++; $display("FAIL fullpop_model: got %h expected %h", i0_data, model_head()); end
    endtask

    task automatic test_stream_wrap();
        do_reset();
        i0_ready = 1'b1; t0_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            t0_data = 32'(k);
            tick();
            n_cmp++; if (i0_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b expected 1", k, i0_valid); end
            n_cmp++; if (i0_data !== 32'(k * 4)) begin n_fail++; $display("FAIL stream_data%0d: got %h expected %h", k, i0_data, 32'(k * 4)); end
            n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d: got %0d expected 1", k, count); end
        end
        t0_valid = 1'b0;
        tick();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain: got %0d expected 0", count); end
    endtask

    task automatic test_truncation();
        do_reset();
        t0_valid = 1'b1; t0_data = 32'hC000_0001;
        tick();
        t0_valid = 1'b0;
        n_cmp++; if (i0_data !== 32'h4) begin n_fail++; $display("FAIL trunc_data: got %h expected 00000004", i0_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i0_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t0_valid = 1'b1; t0_data = 32'h100 + 32'(k);
            tick();
        end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_count_pre: got %0d expected 3", count); end
        rst = 1'b1; t0_data = 32'h77;
        tick();
        rst = 1'b0; t0_valid = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count); end
        n_cmp++; if (i0_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", i0_valid); end
        n_cmp++; if (i0_data !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", i0_data); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL mid_afull: got %b expected 0", almost_full); end
        i0_ready = 1'b1;
        tick();
        n_cmp++; if (i0_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b expected 0", i0_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            t0_valid = ($urandom_range(0, 99) < 60);
            i0_ready = ($urandom_range(0, 99) < 55);
            t0_data  = $urandom;
            tick();
            n_cmp++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count%0d: got %0d expected %0d", c, count, mq.size()); end
            n_cmp++; if (i0_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid%0d: got %b expected %b", c, i0_valid, mq.size() != 0); end
            n_cmp++; if (i0_data !== model_head()) begin n_fail++; $display("FAIL rnd_data%0d: got %h expected %h", c, i0_data, model_head()); end
            n_cmp++; if (almost_full !== (mq.size() >= 3)) begin n_fail++; $display("FAIL rnd_afull%0d: got %b expected %b", c, almost_full, mq.size() >= 3); end
            n_cmp++; if (t0_ready !== (!rst && mq.size() < 4)) begin n_fail++; $display("FAIL rnd_ready%0d: got %b expected %b", c, t0_ready, !rst && mq.size() < 4); end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; t0_valid = 1'b0; t0_data = '0; i0_ready = 1'b0;
        test_reset();
        test_fill_stall();
        test_full_pop();
        test_stream_wrap();
        test_truncation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
